// File: rtl/conv_window_gen.sv
// Streaming 3x3 window generator: two line buffers plus a 3x3 shift register turn a
// raster pixel stream into valid-only windows (no border padding), one cycle after the pixel.
module conv_window_gen #(
    parameter int DATA_WIDTH = 8,
    parameter int IMG_WIDTH  = 32,
    parameter int IMG_HEIGHT = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [DATA_WIDTH-1:0]     pix_in,
    input  logic                      pix_valid_in,
    input  logic                      sof_in,
    output logic [9*DATA_WIDTH-1:0]   window_out,
    output logic                      window_valid_out,
    output logic                      frame_done_out
);

    localparam int COL_W = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
    localparam int ROW_W = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_WIDTH - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_HEIGHT - 1);
    localparam logic [COL_W-1:0] COL_TWO  = COL_W'(2);
    localparam logic [ROW_W-1:0] ROW_TWO  = ROW_W'(2);

    logic [COL_W-1:0]      col;
    logic [ROW_W-1:0]      row;
    logic [COL_W-1:0]      pos_col;
    logic [ROW_W-1:0]      pos_row;
    logic [COL_W-1:0]      col_next;
    logic [ROW_W-1:0]      row_next;
    logic                  emit;
    logic                  last_pix;

    // line_old holds row r-2, line_mid holds row r-1 at each column
    logic [DATA_WIDTH-1:0] line_old [IMG_WIDTH];
    logic [DATA_WIDTH-1:0] line_mid [IMG_WIDTH];

    logic [DATA_WIDTH-1:0] tap         [3];
    logic [DATA_WIDTH-1:0] win_sr      [3][3];
    logic [DATA_WIDTH-1:0] win_sr_next [3][3];
    logic [9*DATA_WIDTH-1:0] win_flat;

    // A start-of-frame pixel is always (0,0), whatever the counters say
    always_comb begin
        pos_col = sof_in ? '0 : col;
        pos_row = sof_in ? '0 : row;
    end

    always_comb begin
        last_pix = (pos_col == COL_LAST) && (pos_row == ROW_LAST);
        emit     = pix_valid_in && (pos_col >= COL_TWO) && (pos_row >= ROW_TWO);
    end

    always_comb begin
        col_next = pos_col + COL_W'(1);
        row_next = pos_row;
        if (last_pix) begin
            col_next = '0;
            row_next = '0;
        end else if (pos_col == COL_LAST) begin
            col_next = '0;
            row_next = pos_row + ROW_W'(1);
        end
    end

    always_comb begin
        tap[0] = line_old[pos_col];
        tap[1] = line_mid[pos_col];
        tap[2] = pix_in;
    end

    // Windows only fire at col >= 2, so by then the shift register has been
    // refilled with three columns of the current row and never spans a row wrap.
    always_comb begin
        win_sr_next = '{default: '0};
        for (int i = 0; i < 3; i++) begin
            win_sr_next[i][0] = win_sr[i][1];
            win_sr_next[i][1] = win_sr[i][2];
            win_sr_next[i][2] = tap[i];
        end
    end

    always_comb begin
        win_flat = '0;
        for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 3; j++) begin
                win_flat[(3*i+j)*DATA_WIDTH +: DATA_WIDTH] = win_sr_next[i][j];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            col              <= '0;
            row              <= '0;
            win_sr           <= '{default: '0};
            window_out       <= '0;
            window_valid_out <= 1'b0;
            frame_done_out   <= 1'b0;
        end else begin
            window_valid_out <= emit;
            frame_done_out   <= emit && last_pix;
            if (pix_valid_in) begin
                col    <= col_next;
                row    <= row_next;
                win_sr <= win_sr_next;
            end
            if (emit) begin
                window_out <= win_flat;
            end
        end
    end

    // Line buffers are not reset; rows 0..1 of every frame rewrite them before use
    always_ff @(posedge clk) begin
        if (pix_valid_in && !rst) begin
            line_old[pos_col] <= line_mid[pos_col];
            line_mid[pos_col] <= pix_in;
        end
    end

endmodule
